// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - shared size encodings, FSM states and alignment helper for ma_unit_v2
package ma_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } ma_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lsbs);
    logic w_mis;
    case (size)
      SZ_BYTE: w_mis = 1'b0;
      SZ_HALF: w_mis = addr_lsbs[0];
      SZ_WORD: w_mis = |addr_lsbs[1:0];
      default: w_mis = |addr_lsbs;
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/ma_lane_align.sv
// rtl/ma_lane_align.sv - byte-lane steering: store enables/replication and load extract/extension
module ma_lane_align
  import ma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LW     = $clog2(DATA_W / 8)
) (
  input  logic [1:0]          i_size,
  input  logic [LW-1:0]       i_lane,
  input  logic                i_is_unsigned,
  input  logic [DATA_W-1:0]   i_wd,
  input  logic [DATA_W-1:0]   i_dout,
  output logic [DATA_W/8-1:0] o_be,
  output logic [DATA_W-1:0]   o_din,
  output logic [DATA_W-1:0]   o_ld_data
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] w_shift;

  // Bring the addressed lane down to bit 0 so every size extracts from the bottom.
  assign w_shift = i_dout >> {i_lane, 3'b000};

  always_comb begin
    o_be      = '1;
    o_din     = i_wd;
    o_ld_data = i_dout;
    case (i_size)
      SZ_BYTE: begin
        o_be  = NB'(1'b1) << i_lane;
        o_din = {NB{i_wd[7:0]}};
        if (i_is_unsigned) o_ld_data = DATA_W'(w_shift[7:0]);
        else               o_ld_data = DATA_W'($signed(w_shift[7:0]));
      end
      SZ_HALF: begin
        o_be  = NB'(2'b11) << i_lane;
        o_din = {(NB/2){i_wd[15:0]}};
        if (i_is_unsigned) o_ld_data = DATA_W'(w_shift[15:0]);
        else               o_ld_data = DATA_W'($signed(w_shift[15:0]));
      end
      SZ_WORD: begin
        o_be  = NB'(4'hF) << i_lane;
        o_din = {(NB/4){i_wd[31:0]}};
        if (i_is_unsigned) o_ld_data = DATA_W'(w_shift[31:0]);
        else               o_ld_data = DATA_W'($signed(w_shift[31:0]));
      end
      default: begin
        o_be      = '1;
        o_din     = i_wd;
        o_ld_data = i_dout;
      end
    endcase
  end

endmodule

// File: rtl/ma_unit_v2.sv
// rtl/ma_unit_v2.sv - MA-stage load/store unit driving a synchronous byte-enabled data memory
module ma_unit_v2
  import ma_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int MEM_LATENCY = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  input  logic                                 i_is_ld,
  input  logic                                 i_is_st,
  input  logic [1:0]                           i_size,
  input  logic                                 i_is_unsigned,
  input  logic [ADDR_W-1:0]                    i_addr,
  input  logic [DATA_W-1:0]                    i_wd,
  output logic [DATA_W-1:0]                    o_rd_data,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic                                 o_busy,
  output logic                                 o_mem_en,
  output logic [DATA_W/8-1:0]                  o_mem_we,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]                    o_mem_din,
  input  logic [DATA_W-1:0]                    i_mem_dout
);

  localparam int LW = $clog2(DATA_W / 8);

  ma_state_t           r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_uns;
  logic                r_is_st;
  logic [DATA_W-1:0]   r_wd;
  logic [2:0]          r_cnt;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_accept;
  logic                w_bad;
  logic                w_size_bad;
  logic [DATA_W/8-1:0] w_be;
  logic [DATA_W-1:0]   w_din;
  logic [DATA_W-1:0]   w_ld_data;

  // Doubles only exist on a 64-bit memory; on 32-bit they are malformed.
  assign w_size_bad = (i_size == SZ_DBL) && (DATA_W == 32);
  assign w_bad      = (i_is_ld & i_is_st) | w_size_bad | is_misaligned(i_size, i_addr[2:0]);
  assign w_accept   = i_req_valid & o_req_ready & (i_is_ld | i_is_st);

  ma_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size        (r_size),
    .i_lane        (r_addr[LW-1:0]),
    .i_is_unsigned (r_uns),
    .i_wd          (r_wd),
    .i_dout        (i_mem_dout),
    .o_be          (w_be),
    .o_din         (w_din),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_next = w_bad ? ERR : ISSUE;
      ISSUE:    w_next = r_is_st ? DONE : WAIT;
      WAIT:     if (r_cnt == 3'd0) w_next = DONE;
      DONE:     w_next = IDLE;
      ERR:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_size    <= SZ_BYTE;
      r_uns     <= 1'b0;
      r_is_st   <= 1'b0;
      r_wd      <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_addr;
        r_size  <= i_size;
        r_uns   <= i_is_unsigned;
        r_is_st <= i_is_st;
        r_wd    <= i_wd;
      end
      if (r_state == ISSUE)     r_cnt <= 3'(MEM_LATENCY - 1);
      else if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
      if (r_state == WAIT && r_cnt == 3'd0) r_rd_data <= w_ld_data;
    end
  end

  assign o_req_ready = (r_state == IDLE) & ~i_reset;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE) | (r_state == ERR);
  assign o_err       = (r_state == ERR);
  assign o_mem_en    = (r_state == ISSUE);
  assign o_mem_we    = (r_state == ISSUE && r_is_st) ? w_be : '0;
  assign o_mem_addr  = r_addr[ADDR_W-1:LW];
  assign o_mem_din   = w_din;
  assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_ma_unit_v2.sv
// tb/tb_ma_unit_v2.sv - directed bench for ma_unit_v2 across 32/64-bit widths and latencies 1 and 3
module tb_ma_unit_v2;

  logic        clk;
  logic        t_reset;
  logic        t_valid;
  logic [1:0]  sel;
  logic        t_is_ld, t_is_st, t_uns;
  logic [1:0]  t_size;
  logic [8:0]  t_addr;
  logic [63:0] t_wd;

  logic        a_ready, a_done, a_err, a_busy, a_en;
  logic [3:0]  a_we;
  logic [6:0]  a_maddr;
  logic [31:0] a_din, a_rd, a_dout;
  logic        b_ready, b_done, b_err, b_busy, b_en;
  logic [3:0]  b_we;
  logic [6:0]  b_maddr;
  logic [31:0] b_din, b_rd, b_dout;
  logic        c_ready, c_done, c_err, c_busy, c_en;
  logic [7:0]  c_we;
  logic [5:0]  c_maddr;
  logic [63:0] c_din, c_rd, c_dout;

  logic        ob_ready, ob_done, ob_err, ob_busy, ob_en;
  logic [7:0]  ob_we;
  logic [8:0]  ob_addr;
  logic [63:0] ob_din, ob_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int err_glitch = 0;
  int done_cyc, en_cyc, busy_cnt, ready_hi, done_seen;
  logic        err_cap;
  logic [7:0]  we_cap;
  logic [8:0]  addr_cap;
  logic [63:0] din_cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ma_unit_v2 #(.DATA_W(32), .ADDR_W(9), .MEM_LATENCY(1)) u_dut_a (
    .i_clk(clk), .i_reset(t_reset), .i_req_valid(t_valid & (sel == 2'd0)), .o_req_ready(a_ready),
    .i_is_ld(t_is_ld), .i_is_st(t_is_st), .i_size(t_size), .i_is_unsigned(t_uns),
    .i_addr(t_addr), .i_wd(t_wd[31:0]), .o_rd_data(a_rd), .o_done(a_done), .o_err(a_err),
    .o_busy(a_busy), .o_mem_en(a_en), .o_mem_we(a_we), .o_mem_addr(a_maddr),
    .o_mem_din(a_din), .i_mem_dout(a_dout)
  );

  ma_unit_v2 #(.DATA_W(32), .ADDR_W(9), .MEM_LATENCY(3)) u_dut_b (
    .i_clk(clk), .i_reset(t_reset), .i_req_valid(t_valid & (sel == 2'd1)), .o_req_ready(b_ready),
    .i_is_ld(t_is_ld), .i_is_st(t_is_st), .i_size(t_size), .i_is_unsigned(t_uns),
    .i_addr(t_addr), .i_wd(t_wd[31:0]), .o_rd_data(b_rd), .o_done(b_done), .o_err(b_err),
    .o_busy(b_busy), .o_mem_en(b_en), .o_mem_we(b_we), .o_mem_addr(b_maddr),
    .o_mem_din(b_din), .i_mem_dout(b_dout)
  );

  ma_unit_v2 #(.DATA_W(64), .ADDR_W(9), .MEM_LATENCY(1)) u_dut_c (
    .i_clk(clk), .i_reset(t_reset), .i_req_valid(t_valid & (sel == 2'd2)), .o_req_ready(c_ready),
    .i_is_ld(t_is_ld), .i_is_st(t_is_st), .i_size(t_size), .i_is_unsigned(t_uns),
    .i_addr(t_addr), .i_wd(t_wd), .o_rd_data(c_rd), .o_done(c_done), .o_err(c_err),
    .o_busy(c_busy), .o_mem_en(c_en), .o_mem_we(c_we), .o_mem_addr(c_maddr),
    .o_mem_din(c_din), .i_mem_dout(c_dout)
  );

  // Memory models: registered read, byte-lane write
  logic [31:0] mem_a [0:127];
  logic [63:0] mem_c [0:63];
  logic [31:0] b_p0, b_p1, b_p2;

  always @(posedge clk) begin
    if (a_en) begin
      for (int i = 0; i < 4; i++) if (a_we[i]) mem_a[a_maddr][8*i +: 8] <= a_din[8*i +: 8];
      a_dout <= mem_a[a_maddr];
    end
  end

  always @(posedge clk) begin
    if (c_en) begin
      for (int i = 0; i < 8; i++) if (c_we[i]) mem_c[c_maddr][8*i +: 8] <= c_din[8*i +: 8];
      c_dout <= mem_c[c_maddr];
    end
  end

  // Latency-3 memory: the read value is present only in the cycle it is due
  always @(posedge clk) begin
    b_p0 <= b_en ? 32'h600D_F00D : 32'h0;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_dout = b_p2;

  always_comb begin
    ob_ready = a_ready; ob_done = a_done; ob_err = a_err; ob_busy = a_busy; ob_en = a_en;
    ob_we = {4'h0, a_we}; ob_addr = {2'b0, a_maddr}; ob_din = {32'h0, a_din}; ob_rd = {32'h0, a_rd};
    case (sel)
      2'd1: begin
        ob_ready = b_ready; ob_done = b_done; ob_err = b_err; ob_busy = b_busy; ob_en = b_en;
        ob_we = {4'h0, b_we}; ob_addr = {2'b0, b_maddr}; ob_din = {32'h0, b_din}; ob_rd = {32'h0, b_rd};
      end
      2'd2: begin
        ob_ready = c_ready; ob_done = c_done; ob_err = c_err; ob_busy = c_busy; ob_en = c_en;
        ob_we = c_we; ob_addr = {3'b0, c_maddr}; ob_din = c_din; ob_rd = c_rd;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the selected unit idle; returns at the negedge of done (bounded).
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [8:0] ad, input logic [63:0] d, input bit hold);
    t_is_ld = ld; t_is_st = st; t_size = sz; t_uns = uns; t_addr = ad; t_wd = d;
    t_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) t_valid = 1'b0;
    done_cyc = 0; en_cyc = 0; busy_cnt = 0; ready_hi = 0;
    err_cap = 1'b0; we_cap = '0; addr_cap = '0; din_cap = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ob_busy) busy_cnt++;
      if (ob_ready) ready_hi++;
      if (ob_err && !ob_done) err_glitch++;
      if (ob_en) begin
        en_cyc = c; we_cap = ob_we; addr_cap = ob_addr; din_cap = ob_din;
      end
      if (ob_done) begin
        done_cyc = c; err_cap = ob_err;
        break;
      end
    end
  endtask

  task automatic check_reject(input string tag, input logic [63:0] rd_exp);
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'd1);
    check_eq({tag, "_err"}, 64'(err_cap), 64'd1);
    check_eq({tag, "_mem_en_cyc"}, 64'(en_cyc), 64'd0);
    check_eq({tag, "_rd_kept"}, ob_rd, rd_exp);
  endtask

  initial begin
    sel = 2'd0; t_valid = 1'b0; t_is_ld = 1'b0; t_is_st = 1'b0; t_size = 2'b00;
    t_uns = 1'b0; t_addr = '0; t_wd = '0;
    t_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 t_reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready",   64'(ob_ready), 64'd1);
    check_eq("rst_busy",    64'(ob_busy),  64'd0);
    check_eq("rst_done",    64'(ob_done),  64'd0);
    check_eq("rst_err",     64'(ob_err),   64'd0);
    check_eq("rst_mem_en",  64'(ob_en),    64'd0);
    check_eq("rst_mem_we",  64'(ob_we),    64'd0);
    check_eq("rst_mem_addr", 64'(ob_addr), 64'd0);
    check_eq("rst_mem_din", ob_din,        64'd0);
    check_eq("rst_rd_data", ob_rd,         64'd0);

    // 32-bit, latency 1
    do_op(1'b0, 1'b1, 2'b10, 1'b0, 9'h010, 64'hDEADBEEF, 1'b0);
    check_eq("stw_en_cyc", 64'(en_cyc), 64'd1);
    check_eq("stw_we", 64'(we_cap), 64'hF);
    check_eq("stw_addr", 64'(addr_cap), 64'h04);
    check_eq("stw_din", din_cap, 64'hDEADBEEF);
    check_eq("stw_done_cyc", 64'(done_cyc), 64'd2);
    check_eq("stw_err", 64'(err_cap), 64'd0);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 64'h0, 1'b0);
    check_eq("ldw_en_cyc", 64'(en_cyc), 64'd1);
    check_eq("ldw_we", 64'(we_cap), 64'h0);
    check_eq("ldw_done_cyc", 64'(done_cyc), 64'd3);
    check_eq("ldw_err", 64'(err_cap), 64'd0);
    check_eq("ldw_rd", ob_rd, 64'hDEADBEEF);
    @(negedge clk);
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 9'h013, 64'h80, 1'b0);
    check_eq("stb_we", 64'(we_cap), 64'h8);
    check_eq("stb_din", din_cap, 64'h80808080);
    check_eq("stb_done_cyc", 64'(done_cyc), 64'd2);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b00, 1'b0, 9'h013, 64'h0, 1'b0);
    check_eq("ldb_s_rd", ob_rd, 64'hFFFFFF80);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 9'h013, 64'h0, 1'b0);
    check_eq("ldb_u_rd", ob_rd, 64'h00000080);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 9'h012, 64'h0, 1'b0);
    check_eq("ldh_s_rd", ob_rd, 64'hFFFF80AD);
    @(negedge clk);
    do_op(1'b0, 1'b1, 2'b01, 1'b0, 9'h002, 64'hFFFF1234, 1'b0);
    check_eq("sth_we", 64'(we_cap), 64'hC);
    check_eq("sth_addr", 64'(addr_cap), 64'h0);
    check_eq("sth_din", din_cap, 64'h12341234);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 9'h011, 64'h0, 1'b0);
    check_reject("mis_half", 64'hFFFF80AD);
    @(negedge clk);
    do_op(1'b1, 1'b1, 2'b10, 1'b0, 9'h010, 64'h0, 1'b0);
    check_reject("ld_and_st", 64'hFFFF80AD);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b11, 1'b0, 9'h010, 64'h0, 1'b0);
    check_reject("dbl_on_32", 64'hFFFF80AD);
    @(negedge clk);
    do_op(1'b0, 1'b0, 2'b10, 1'b0, 9'h010, 64'h0, 1'b0);
    check_eq("noop_done_cyc", 64'(done_cyc), 64'd0);
    check_eq("noop_busy_cnt", 64'(busy_cnt), 64'd0);

    // 64-bit, latency 1
    sel = 2'd2;
    @(negedge clk);
    do_op(1'b0, 1'b1, 2'b11, 1'b0, 9'h008, 64'h0123456789ABCDEF, 1'b0);
    check_eq("std_we", 64'(we_cap), 64'hFF);
    check_eq("std_addr", 64'(addr_cap), 64'h1);
    check_eq("std_din", din_cap, 64'h0123456789ABCDEF);
    check_eq("std_done_cyc", 64'(done_cyc), 64'd2);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 9'h00E, 64'h0, 1'b0);
    check_eq("c_ldh_u_rd", ob_rd, 64'h0000000000000123);
    check_eq("c_ldh_done_cyc", 64'(done_cyc), 64'd3);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 9'h00C, 64'h0, 1'b0);
    check_eq("c_ldw_s_rd", ob_rd, 64'h0000000001234567);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b00, 1'b0, 9'h008, 64'h0, 1'b0);
    check_eq("c_ldb_s_rd", ob_rd, 64'hFFFFFFFFFFFFFFEF);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b11, 1'b0, 9'h008, 64'h0, 1'b0);
    check_eq("c_ldd_rd", ob_rd, 64'h0123456789ABCDEF);
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b11, 1'b0, 9'h00C, 64'h0, 1'b0);
    check_reject("c_mis_dbl", 64'h0123456789ABCDEF);

    // 32-bit, latency 3, valid held through the access
    sel = 2'd1;
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 64'h0, 1'b1);
    check_eq("l3_done_cyc", 64'(done_cyc), 64'd5);
    check_eq("l3_busy_cnt", 64'(busy_cnt), 64'd5);
    check_eq("l3_ready_hi", 64'(ready_hi), 64'd0);
    check_eq("l3_rd", ob_rd, 64'h600DF00D);
    @(negedge clk);
    check_eq("l3_c6_ready", 64'(ob_ready), 64'd1);
    check_eq("l3_c6_busy", 64'(ob_busy), 64'd0);
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    check_eq("l3_b2b_busy", 64'(ob_busy), 64'd1);
    check_eq("l3_b2b_mem_en", 64'(ob_en), 64'd1);
    @(negedge clk);
    t_reset = 1'b1;
    @(posedge clk); #1;
    t_reset = 1'b0;
    @(negedge clk);
    check_eq("abort_mem_en", 64'(ob_en), 64'd0);
    check_eq("abort_busy", 64'(ob_busy), 64'd0);
    check_eq("abort_ready", 64'(ob_ready), 64'd1);
    check_eq("abort_rd", ob_rd, 64'd0);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ob_done) done_seen++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);

    check_eq("err_without_done", 64'(err_glitch), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
